// File: rtl/instr_fetch_unit_if.sv
// Purpose: bundles the instruction-memory byte port and the downstream instruction port.
// Latency: none; wiring only.
// Backpressure: mem_ack paces the memory side, instr_ready paces the instruction side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8
);

  // redirect from the controller
  logic [ADDR_W-1:0] pc_in;
  logic              pc_load;

  // byte-wide instruction memory, req/ack
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  // assembled instruction, valid/ready
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  // fetch unit side
  modport master (
    input  pc_in,
    input  pc_load,
    output mem_addr,
    output mem_req,
    input  mem_ack,
    input  mem_rdata,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready
  );

  // memory model / controller side
  modport slave (
    output pc_in,
    output pc_load,
    input  mem_addr,
    input  mem_req,
    output mem_ack,
    output mem_rdata,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose: fetches four bytes over req/ack and assembles them little-endian into one instruction.
// Latency: word valid 4 ack edges after entering FETCH (5 edges after reset release with ack tied 1).
// Backpressure: instr held stable while instr_ready=0; fetching stops when no storage is free.
// Optional IFETCH_PREFETCH_EN adds a one-word prefetch slot so fetching overlaps the output hold.
module instr_fetch_unit #(
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             reset,   // synchronous, active low
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [23:0]       asm_q, asm_d;          // bytes 0..2 of the word being built
  logic              mem_req_q, mem_req_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;

`ifdef IFETCH_PREFETCH_EN
  logic [31:0]       slot_q, slot_d;
  logic [ADDR_W-1:0] slot_pc_q, slot_pc_d;
  logic              slot_vld_q, slot_vld_d;
  logic              slot_full;
`endif

  logic              ack_take;
  logic              xfer;
  logic              word_done;
  logic [31:0]       new_word;
  logic [ADDR_W-1:0] new_word_pc;
  logic              out_full;
  logic              stall;

  // Next-state: redirect beats byte acceptance and output transfer; reset handled in the flops.
  always_comb begin
    state_d       = state_q;
    bcnt_d        = bcnt_q;
    fetch_addr_d  = fetch_addr_q;
    asm_d         = asm_q;
    mem_req_d     = mem_req_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
`ifdef IFETCH_PREFETCH_EN
    slot_d        = slot_q;
    slot_pc_d     = slot_pc_q;
    slot_vld_d    = slot_vld_q;
    slot_full     = 1'b0;
`endif

    // mem_req_q is high exactly while in FETCH, so the state alone qualifies an ack
    ack_take    = (state_q == S_FETCH) && bus.mem_ack;
    xfer        = instr_valid_q && bus.instr_ready;
    word_done   = ack_take && (bcnt_q == 2'd3);
    new_word    = {bus.mem_rdata, asm_q};
    // the last byte sits three above byte 0; subtraction wraps like the increments
    new_word_pc = fetch_addr_q - ADDR_W'(3);
    out_full    = 1'b0;
    stall       = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d   = S_FETCH;
        mem_req_d = 1'b1;
      end

      default: begin
        if (bus.pc_load) begin
          // Redirect: drop partial bytes and any buffered words; a same-cycle ack is ignored.
          // instr/instr_pc keep their old contents, only the valid flag drops.
          state_d       = S_FETCH;
          mem_req_d     = 1'b1;
          bcnt_d        = 2'd0;
          fetch_addr_d  = bus.pc_in;
          instr_valid_d = 1'b0;
`ifdef IFETCH_PREFETCH_EN
          slot_vld_d    = 1'b0;
`endif
        end else begin
          // accept one byte into the assembly register
          if (ack_take) begin
            case (bcnt_q)
              2'd0:    asm_d[7:0]   = bus.mem_rdata;
              2'd1:    asm_d[15:8]  = bus.mem_rdata;
              2'd2:    asm_d[23:16] = bus.mem_rdata;
              default: ;
            endcase
            bcnt_d       = bcnt_q + 2'd1;
            fetch_addr_d = fetch_addr_q + ADDR_W'(1);
          end

          // output register occupancy after any transfer at this edge
          out_full = instr_valid_q && !xfer;
          if (xfer) begin
            instr_valid_d = 1'b0;
          end

`ifdef IFETCH_PREFETCH_EN
          // a buffered word refills the output in the same edge it drains
          slot_full = slot_vld_q;
          if (xfer && slot_vld_q) begin
            instr_d       = slot_q;
            instr_pc_d    = slot_pc_q;
            instr_valid_d = 1'b1;
            slot_vld_d    = 1'b0;
            out_full      = 1'b1;
            slot_full     = 1'b0;
          end
`endif

          // a completed word goes to the output if free, else to the slot
          if (word_done) begin
            if (!out_full) begin
              instr_d       = new_word;
              instr_pc_d    = new_word_pc;
              instr_valid_d = 1'b1;
              out_full      = 1'b1;
            end
`ifdef IFETCH_PREFETCH_EN
            else begin
              slot_d     = new_word;
              slot_pc_d  = new_word_pc;
              slot_vld_d = 1'b1;
              slot_full  = 1'b1;
            end
`endif
          end

          // stop requesting only when every word buffer is occupied
`ifdef IFETCH_PREFETCH_EN
          stall = out_full && slot_full;
`else
          stall = out_full;
`endif
          state_d   = stall ? S_HOLD : S_FETCH;
          mem_req_d = !stall;
        end
      end
    endcase
  end

  // State and registered outputs; reset is synchronous and overrides everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      bcnt_q        <= 2'd0;
      fetch_addr_q  <= '0;
      asm_q         <= '0;
      mem_req_q     <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
      slot_q        <= '0;
      slot_pc_q     <= '0;
      slot_vld_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bcnt_q        <= bcnt_d;
      fetch_addr_q  <= fetch_addr_d;
      asm_q         <= asm_d;
      mem_req_q     <= mem_req_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
`ifdef IFETCH_PREFETCH_EN
      slot_q        <= slot_d;
      slot_pc_q     <= slot_pc_d;
      slot_vld_q    <= slot_vld_d;
`endif
    end
  end

  // The fetch address register is the memory address; it only moves after an accepted ack.
  assign bus.mem_addr    = fetch_addr_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;

endmodule
